// File: rtl/button_pkg.sv
// Shared state encoding, sim-scale timing constants and helpers for the button_array block.
package button_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOCK     = 3'd1;
  localparam state_t ST_HELD     = 3'd2;
  localparam state_t ST_LONG     = 3'd3;
  localparam state_t ST_REL_LOCK = 3'd4;

  // Scaled-down timing used by simulation benches.
  localparam int SIM_LOCK_CYCLES   = 16;
  localparam int SIM_LONG_CYCLES   = 64;
  localparam int SIM_REPEAT_CYCLES = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 3-flop synchroniser, lockout/long-press FSM and its counter.
// Auto-repeat in the LONG state is built only when BUTTON_AUTO_REPEAT_EN is defined.
module button_channel
  import button_pkg::*;
#(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int LOCK_CYCLES   = 24000000,
  parameter int LONG_CYCLES   = 48000000,
  parameter int REPEAT_CYCLES = 6000000
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   raw,
  output logic   press_pulse,
  output logic   long_pulse,
  output logic   repeat_pulse,
  output logic   release_pulse,
  output logic   held,
  output state_t state
);

  localparam int CNT_W = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d, long_q, long_d, rel_q, rel_d;
  logic             s2_act, s3_act, press_edge;
`ifdef BUTTON_AUTO_REPEAT_EN
  logic             rep_q, rep_d;
`endif

  always_comb begin
    s1_d       = raw;
    s2_d       = s1_q;
    s3_d       = s2_q;
    s2_act     = ACTIVE_LOW ? ~s2_q : s2_q;
    s3_act     = ACTIVE_LOW ? ~s3_q : s3_q;
    press_edge = s2_act && !s3_act;

    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    long_d  = 1'b0;
    rel_d   = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
    rep_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (press_edge) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        // Input is only looked at once the lockout window has elapsed.
        if (cnt_q == LOCK_LAST) begin
          if (s2_act) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_HELD;
          end else begin
            rel_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_REL_LOCK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!s2_act) begin
          rel_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_REL_LOCK;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_LONG;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LONG: begin
        if (!s2_act) begin
          rel_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_REL_LOCK;
        end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
          if (cnt_q == REP_LAST) begin
            rep_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          cnt_d = '0;
`endif
        end
      end
      ST_REL_LOCK: begin
        if (cnt_q == LOCK_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      long_q  <= 1'b0;
      rel_q   <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_q   <= 1'b0;
`endif
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      long_q  <= long_d;
      rel_q   <= rel_d;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign press_pulse   = press_q;
  assign long_pulse    = long_q;
  assign release_pulse = rel_q;
  // Held drops in the same cycle the release pulse fires, i.e. on REL_LOCK entry.
  assign held          = (state_q == ST_LOCK) || (state_q == ST_HELD) || (state_q == ST_LONG);
  assign state         = state_q;
`ifdef BUTTON_AUTO_REPEAT_EN
  assign repeat_pulse  = rep_q;
`else
  assign repeat_pulse  = 1'b0;
`endif

endmodule

// File: rtl/button_array.sv
// N_CH independent debounced buttons with press/long/repeat/release pulses and a held level.
// Auto-repeat is enabled by defining BUTTON_AUTO_REPEAT_EN.
module button_array
  import button_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int LOCK_CYCLES   = 24000000,
  parameter int LONG_CYCLES   = 48000000,
  parameter int REPEAT_CYCLES = 6000000
) (
  input  logic              Fg_clk,
  input  logic              Reset,
  input  logic [N_CH-1:0]   Ext_button,
  output logic [N_CH-1:0]   Press_pulse,
  output logic [N_CH-1:0]   Long_pulse,
  output logic [N_CH-1:0]   Repeat_pulse,
  output logic [N_CH-1:0]   Release_pulse,
  output logic [N_CH-1:0]   Held,
  output logic [3*N_CH-1:0] Dbg_state
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t ch_state;

    button_channel #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .LOCK_CYCLES  (LOCK_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk          (Fg_clk),
      .rst          (Reset),
      .raw          (Ext_button[i]),
      .press_pulse  (Press_pulse[i]),
      .long_pulse   (Long_pulse[i]),
      .repeat_pulse (Repeat_pulse[i]),
      .release_pulse(Release_pulse[i]),
      .held         (Held[i]),
      .state        (ch_state)
    );

    assign Dbg_state[3*i +: 3] = ch_state;
  end

endmodule

// File: tb/tb_button_array.sv
// Directed plus randomized bench for button_array against a timestamp-based reference model.
module tb_button_array;
  import button_pkg::*;

  localparam int N_CH   = 4;
  localparam bit ACTIVE_LOW = 1'b1;
  localparam int LOCK   = SIM_LOCK_CYCLES;
  localparam int LONG   = SIM_LONG_CYCLES;
  localparam int REPEAT = SIM_REPEAT_CYCLES;
  localparam int MAXC   = 8192;
  localparam int W      = 5 * N_CH;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  localparam int P_IDLE = 0, P_PRESS = 1, P_REL = 2;
  localparam logic [N_CH-1:0] IDLE_LVL = ACTIVE_LOW ? {N_CH{1'b1}} : {N_CH{1'b0}};

  logic              clk;
  logic              Reset;
  logic [N_CH-1:0]   Ext_button;
  logic [N_CH-1:0]   Press_pulse, Long_pulse, Repeat_pulse, Release_pulse, Held;
  logic [3*N_CH-1:0] Dbg_state;

  button_array #(
    .N_CH(N_CH), .ACTIVE_LOW(ACTIVE_LOW), .LOCK_CYCLES(LOCK),
    .LONG_CYCLES(LONG), .REPEAT_CYCLES(REPEAT)
  ) dut (
    .Fg_clk(clk), .Reset(Reset), .Ext_button(Ext_button),
    .Press_pulse(Press_pulse), .Long_pulse(Long_pulse), .Repeat_pulse(Repeat_pulse),
    .Release_pulse(Release_pulse), .Held(Held), .Dbg_state(Dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus history and model state
  logic [N_CH-1:0] hist [0:MAXC];
  logic            rst_h [0:MAXC];
  logic [N_CH-1:0] btn_v;
  logic            rst_v;
  int              k;
  int              phase [N_CH];
  int              tp [N_CH];
  int              tr [N_CH];
  logic [W-1:0]    exp_q[$];
  int              n_tests, n_fail;
  int              c_press [N_CH];
  int              c_long [N_CH];
  int              c_rep [N_CH];
  int              c_rel [N_CH];
  int              c_pair;

  function automatic bit act(input logic v);
    return ACTIVE_LOW ? !v : v;
  endfunction

  // reference model: per-channel press/release timestamps, outputs derived from ages
  task automatic model_step();
    logic [N_CH-1:0] e_press, e_long, e_rep, e_rel, e_held;
    int age;
    bit a, b;
    e_press = '0; e_long = '0; e_rep = '0; e_rel = '0; e_held = '0;
    if (rst_h[k-1]) begin
      for (int ch = 0; ch < N_CH; ch++) phase[ch] = P_IDLE;
      hist[k-1] = '0; hist[k-2] = '0; hist[k-3] = '0;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        a = act(hist[k-3][ch]);
        b = act(hist[k-4][ch]);
        case (phase[ch])
          P_IDLE: if (a && !b) begin
            phase[ch] = P_PRESS; tp[ch] = k; e_press[ch] = 1'b1;
          end
          P_PRESS: begin
            age = k - tp[ch];
            if (age >= LOCK && !a) begin
              e_rel[ch] = 1'b1; phase[ch] = P_REL; tr[ch] = k;
            end else if (age == LONG) begin
              e_long[ch] = 1'b1;
            end else if (REP_EN && age > LONG && ((age - LONG) % REPEAT) == 0) begin
              e_rep[ch] = 1'b1;
            end
          end
          default: if (k - tr[ch] == LOCK) phase[ch] = P_IDLE;
        endcase
        e_held[ch] = (phase[ch] == P_PRESS);
      end
    end
    exp_q.push_back({e_held, e_rel, e_rep, e_long, e_press});
  endtask

  // scoreboard
  task automatic check();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    n_tests += 5;
    assert (Press_pulse === e[0 +: N_CH]) else begin
      n_fail++; $error("FAIL press cyc=%0d got=%b exp=%b", k, Press_pulse, e[0 +: N_CH]);
    end
    assert (Long_pulse === e[N_CH +: N_CH]) else begin
      n_fail++; $error("FAIL long cyc=%0d got=%b exp=%b", k, Long_pulse, e[N_CH +: N_CH]);
    end
    assert (Repeat_pulse === e[2*N_CH +: N_CH]) else begin
      n_fail++; $error("FAIL repeat cyc=%0d got=%b exp=%b", k, Repeat_pulse, e[2*N_CH +: N_CH]);
    end
    assert (Release_pulse === e[3*N_CH +: N_CH]) else begin
      n_fail++; $error("FAIL release cyc=%0d got=%b exp=%b", k, Release_pulse, e[3*N_CH +: N_CH]);
    end
    assert (Held === e[4*N_CH +: N_CH]) else begin
      n_fail++; $error("FAIL held cyc=%0d got=%b exp=%b", k, Held, e[4*N_CH +: N_CH]);
    end
    for (int ch = 0; ch < N_CH; ch++) begin
      c_press[ch] += int'(Press_pulse[ch]);
      c_long[ch]  += int'(Long_pulse[ch]);
      c_rep[ch]   += int'(Repeat_pulse[ch]);
      c_rel[ch]   += int'(Release_pulse[ch]);
    end
    if (Press_pulse === 4'b1001) c_pair++;
  endtask

  // driver
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    model_step();
    check();
    Ext_button = btn_v;
    Reset      = rst_v;
    hist[k]    = btn_v;
    rst_h[k]   = rst_v;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clr_counts();
    for (int ch = 0; ch < N_CH; ch++) begin
      c_press[ch] = 0; c_long[ch] = 0; c_rep[ch] = 0; c_rel[ch] = 0;
    end
    c_pair = 0;
  endtask

  task automatic expect_int(input string tag, input int got, input int want);
    n_tests++;
    assert (got === want) else begin
      n_fail++; $error("FAIL %s got=%0d exp=%0d", tag, got, want);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    btn_v = IDLE_LVL; rst_v = 1'b1;
    Ext_button = IDLE_LVL; Reset = 1'b1;
    for (int i = 0; i <= 3; i++) begin hist[i] = IDLE_LVL; rst_h[i] = 1'b1; end
    for (int ch = 0; ch < N_CH; ch++) begin phase[ch] = P_IDLE; tp[ch] = 0; tr[ch] = 0; end
    k = 3;
    clr_counts();

    run(4);
    n_tests++;
    assert (Dbg_state === {N_CH{ST_IDLE}}) else begin
      n_fail++; $error("FAIL reset_state got=%h exp=%h", Dbg_state, {N_CH{ST_IDLE}});
    end
    rst_v = 1'b0;
    run(6);

    // ch0: bouncy press, hold, bouncy release
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      btn_v[0] = 1'b0; run(1);
      btn_v[0] = 1'b1; run(1);
    end
    btn_v[0] = 1'b0; run(30);
    for (int i = 0; i < 3; i++) begin
      btn_v[0] = 1'b1; run(1);
      btn_v[0] = 1'b0; run(1);
    end
    btn_v[0] = 1'b1; run(40);
    expect_int("bounce_press_cnt", c_press[0], 1);
    expect_int("bounce_release_cnt", c_rel[0], 1);
    expect_int("bounce_long_cnt", c_long[0], 0);

    // ch1: long press with auto-repeat
    clr_counts();
    btn_v[1] = 1'b0; run(100);
    btn_v[1] = 1'b1; run(40);
    expect_int("long_press_cnt", c_press[1], 1);
    expect_int("long_long_cnt", c_long[1], 1);
    expect_int("long_repeat_cnt", c_rep[1], REP_EN ? 4 : 0);
    expect_int("long_release_cnt", c_rel[1], 1);

    // ch2: short press released inside lockout
    clr_counts();
    btn_v[2] = 1'b0; run(5);
    btn_v[2] = 1'b1; run(40);
    expect_int("short_press_cnt", c_press[2], 1);
    expect_int("short_release_cnt", c_rel[2], 1);

    // ch0 and ch3 together
    clr_counts();
    btn_v[0] = 1'b0; btn_v[3] = 1'b0; run(20);
    btn_v[0] = 1'b1; btn_v[3] = 1'b1; run(40);
    expect_int("pair_press_cycles", c_pair, 1);

    // reset during ch1 lockout while held
    clr_counts();
    btn_v[1] = 1'b0; run(8);
    rst_v = 1'b1; run(1);
    rst_v = 1'b0;
    clr_counts();
    run(30);
    expect_int("reset_held_press_cnt", c_press[1], 0);
    expect_int("reset_held_release_cnt", c_rel[1], 0);
    btn_v[1] = 1'b1; run(40);
    btn_v[1] = 1'b0; run(20);
    btn_v[1] = 1'b1; run(40);
    expect_int("reset_repress_cnt", c_press[1], 1);

    // randomized activity on all channels with occasional reset
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < N_CH; ch++)
        if ($urandom_range(0, 19) == 0) btn_v[ch] = ~btn_v[ch];
      rst_v = ($urandom_range(0, 499) == 0);
      run(1);
    end
    rst_v = 1'b0;
    btn_v = IDLE_LVL;
    run(120);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
